// File: rtl/move_cmd_arbiter.sv
// Arbitrates gravity drops and debounced player buttons onto one valid/ready move-command port.
// Optional left/right auto-repeat is built when MOVE_AUTOREPEAT_EN is defined.
module move_cmd_arbiter #(
  parameter int REPEAT_DELAY  = 30,
  parameter int REPEAT_PERIOD = 10,
  parameter int GRAV_MAX      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       rot_r_i,
  input  logic       rot_l_i,
  input  logic       grav_tick_i,
  input  logic       cmd_ready_i,
  output logic       cmd_valid_o,
  output logic [2:0] cmd_o,
  output logic       grav_overflow_o
);

  // state | meaning
  // IDLE  | no command offered; picks a winner when anything is pending
  // OFFER | cmd_o held stable with cmd_valid_o high until accepted or en_i drops
  typedef enum logic {IDLE, OFFER} state_t;

  localparam logic [2:0] CMD_DROP = 3'd0;
  localparam int GW = (GRAV_MAX < 2) ? 1 : $clog2(GRAV_MAX + 1);

  state_t state, state_n;
  logic [2:0] cmd_r, cmd_n;
  logic [1:0] ptr, ptr_n;

  logic [3:0] raw, sync1, sync2, prev, rise;
  logic [3:0] pend, pend_set, pend_clr, repeat_evt;
  logic [GW-1:0] grav_cnt;
  logic grav_ovf;

  logic accept, drop_acc, grav_pend, any_req;
  logic [2:0] winner;
  logic [1:0] user_idx;

  assign raw = {rot_l_i, rot_r_i, right_i, left_i};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

`ifdef MOVE_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [RW-1:0] hold_l, hold_r;
  logic [1:0] rpt;

  // Event fires on the edge the hold count would reach REPEAT_DELAY.
  assign rpt[0] = en_i & sync2[0] & (hold_l == RW'(REPEAT_DELAY - 1));
  assign rpt[1] = en_i & sync2[1] & (hold_r == RW'(REPEAT_DELAY - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_l <= '0;
      hold_r <= '0;
    end else begin
      if (!en_i || !sync2[0])
        hold_l <= '0;
      else if (rpt[0])
        hold_l <= RW'(REPEAT_DELAY - REPEAT_PERIOD);
      else
        hold_l <= hold_l + 1'b1;
      if (!en_i || !sync2[1])
        hold_r <= '0;
      else if (rpt[1])
        hold_r <= RW'(REPEAT_DELAY - REPEAT_PERIOD);
      else
        hold_r <= hold_r + 1'b1;
    end
  end

  assign repeat_evt = {2'b00, rpt};
`else
  assign repeat_evt = '0;
`endif

  assign accept    = (state == OFFER) & cmd_ready_i;
  assign drop_acc  = accept & (cmd_r == CMD_DROP);
  assign user_idx  = 2'(cmd_r - 3'd1);
  assign pend_set  = rise | repeat_evt;
  assign pend_clr  = (accept && cmd_r != CMD_DROP) ? (4'b0001 << user_idx) : 4'b0000;
  assign grav_pend = (grav_cnt != '0);
  assign any_req   = grav_pend | (|pend);

  // Set wins over clear so a re-press during acceptance is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pend <= '0;
    else if (!en_i)
      pend <= '0;
    else
      pend <= (pend & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grav_cnt <= '0;
      grav_ovf <= 1'b0;
    end else if (!en_i) begin
      grav_cnt <= '0;
    end else if (grav_tick_i && !drop_acc) begin
      if (grav_cnt == GW'(GRAV_MAX))
        grav_ovf <= 1'b1;
      else
        grav_cnt <= grav_cnt + 1'b1;
    end else if (!grav_tick_i && drop_acc) begin
      grav_cnt <= grav_cnt - 1'b1;
    end
  end

  always_comb begin
    logic       found;
    logic [1:0] idx;
    winner = CMD_DROP;
    found  = grav_pend;
    idx    = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && pend[idx]) begin
        winner = {1'b0, idx} + 3'd1;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cmd_r <= CMD_DROP;
      ptr   <= 2'd3;
    end else begin
      state <= state_n;
      cmd_r <= cmd_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n = state;
    cmd_n   = cmd_r;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (en_i && any_req) begin
          state_n = OFFER;
          cmd_n   = winner;
        end
      end
      OFFER: begin
        if (!en_i) begin
          state_n = IDLE;
        end else if (accept) begin
          state_n = IDLE;
          if (cmd_r != CMD_DROP)
            ptr_n = user_idx;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign cmd_valid_o     = (state == OFFER);
  assign cmd_o           = cmd_r;
  assign grav_overflow_o = grav_ovf;

endmodule

// File: tb/tb_move_cmd_arbiter.sv
// Directed bench for move_cmd_arbiter: expected commands are queued as stimulus is applied
// and compared against every accepted handshake.
module tb_move_cmd_arbiter;

  logic clk = 1'b0;
  logic reset, en_i, left_i, right_i, rot_r_i, rot_l_i, grav_tick_i, cmd_ready_i;
  logic cmd_valid_o, grav_overflow_o;
  logic [2:0] cmd_o;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  move_cmd_arbiter dut (
    .clk(clk), .reset(reset), .en_i(en_i),
    .left_i(left_i), .right_i(right_i), .rot_r_i(rot_r_i), .rot_l_i(rot_l_i),
    .grav_tick_i(grav_tick_i), .cmd_ready_i(cmd_ready_i),
    .cmd_valid_o(cmd_valid_o), .cmd_o(cmd_o), .grav_overflow_o(grav_overflow_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Handshake seen at negedge completes on the following posedge.
  always @(negedge clk) begin
    logic [2:0] e;
    if (reset === 1'b0 && cmd_valid_o === 1'b1 && cmd_ready_i === 1'b1) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 3'd7;
      checks++;
      assert (cmd_o === e) else begin
        errors++;
        $error("FAIL accepted_cmd observed %0d expected %0d (7 = none expected)", cmd_o, e);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (cmd_valid_o !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(cmd_valid_o), 32'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; en_i = 1'b1; cmd_ready_i = 1'b1; grav_tick_i = 1'b0;
    left_i = 1'b0; right_i = 1'b0; rot_r_i = 1'b0; rot_l_i = 1'b0;
    step(3);
    chk("reset_valid", 32'(cmd_valid_o), 32'd0);
    chk("reset_cmd", 32'(cmd_o), 32'd0);
    chk("reset_ovf", 32'(grav_overflow_o), 32'd0);
    reset = 1'b0;
    step();

    // Left press latency: raw rises before edge k, valid after k+3
    left_i = 1'b1;
    exp_q.push_back(3'd1);
    step();
    step();
    chk("lat_k1_valid", 32'(cmd_valid_o), 32'd0);
    step();
    chk("lat_k2_valid", 32'(cmd_valid_o), 32'd0);
    step();
    chk("lat_k3_valid", 32'(cmd_valid_o), 32'd1);
    chk("lat_k3_cmd", 32'(cmd_o), 32'd1);
    step();
    chk("lat_k4_valid", 32'(cmd_valid_o), 32'd0);
`ifdef MOVE_AUTOREPEAT_EN
    // Repeats at 30, 40, 50 cycles of synchronised hold; released before 60
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd1);
    step(51);
`else
    step(50);
`endif
    left_i = 1'b0;
    drain("left_drain", 40);
    step(10);
    chk("left_no_extra", 32'(cmd_valid_o), 32'd0);

    // Gravity and right pending in the same cycle: DROP first
    right_i = 1'b1;
    step();
    step();
    grav_tick_i = 1'b1;
    step();
    grav_tick_i = 1'b0;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd2);
    step();
    chk("grav_first_valid", 32'(cmd_valid_o), 32'd1);
    chk("grav_first_cmd", 32'(cmd_o), 32'd0);
    drain("grav_drain", 20);
    right_i = 1'b0;
    step(5);

    // Round robin from reset pointer
    do_reset();
    {rot_l_i, rot_r_i, right_i, left_i} = 4'hF;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd4);
    drain("rr4_drain", 40);
    {rot_l_i, rot_r_i, right_i, left_i} = 4'h0;
    step(5);
    rot_l_i = 1'b1;
    left_i = 1'b1;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd4);
    drain("rr_lft_rotl_drain", 30);
    rot_l_i = 1'b0;
    left_i = 1'b0;
    step(5);
    right_i = 1'b1;
    exp_q.push_back(3'd2);
    drain("rr_right_drain", 20);
    right_i = 1'b0;
    step(5);
    // Pointer now at RIGHT, so ROT_R is searched before LEFT
    left_i = 1'b1;
    rot_r_i = 1'b1;
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd1);
    drain("rr_ptr_drain", 30);
    left_i = 1'b0;
    rot_r_i = 1'b0;
    step(5);

    // Backpressure with 5 gravity ticks
    cmd_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      grav_tick_i = 1'b1;
      step();
      grav_tick_i = 1'b0;
      step(3);
      if (i == 0) begin
        chk("bp_first_valid", 32'(cmd_valid_o), 32'd1);
        chk("bp_first_cmd", 32'(cmd_o), 32'd0);
      end
      if (i == 2) chk("bp_ovf_not_yet", 32'(grav_overflow_o), 32'd0);
      if (i == 3) chk("bp_ovf_set", 32'(grav_overflow_o), 32'd1);
    end
    chk("bp_hold_valid", 32'(cmd_valid_o), 32'd1);
    chk("bp_hold_cmd", 32'(cmd_o), 32'd0);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd0);
    cmd_ready_i = 1'b1;
    drain("bp_drain", 30);
    step(8);
    chk("bp_no_extra", 32'(cmd_valid_o), 32'd0);

    // en_i low aborts an offer
    cmd_ready_i = 1'b0;
    left_i = 1'b1;
    wait_valid("abort_wait", 20);
    chk("abort_cmd", 32'(cmd_o), 32'd1);
    en_i = 1'b0;
    step();
    chk("abort_drop", 32'(cmd_valid_o), 32'd0);
    left_i = 1'b0;
    step(3);
    en_i = 1'b1;
    cmd_ready_i = 1'b1;
    step(20);
    chk("abort_no_later", 32'(cmd_valid_o), 32'd0);
    chk("ovf_sticky", 32'(grav_overflow_o), 32'd1);

    // Asynchronous reset mid-offer
    cmd_ready_i = 1'b0;
    rot_r_i = 1'b1;
    wait_valid("rst_wait", 20);
    chk("rst_pre_cmd", 32'(cmd_o), 32'd3);
    rot_r_i = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("rst_async_valid", 32'(cmd_valid_o), 32'd0);
    chk("rst_async_cmd", 32'(cmd_o), 32'd0);
    chk("rst_async_ovf", 32'(grav_overflow_o), 32'd0);
    step(2);
    reset = 1'b0;
    cmd_ready_i = 1'b1;
    step(20);
    chk("rst_no_later", 32'(cmd_valid_o), 32'd0);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_cmd_arbiter.md
Name: move_cmd_arbiter

Overview:
- Sits between the push-button inputs and gravity tick on one side and the Tetris game FSM's single move-command port on the other.
- Synchronises and edge-detects the player buttons, and optionally auto-repeats left/right.
- Queues one pending request per source and arbitrates them onto a valid/ready command channel.
- Priority rule: gravity drops are never lost and win over player moves; player moves are served round-robin.

Parameters:
- REPEAT_DELAY, 30: cycles a left/right button must be held before the first auto-repeat.
- REPEAT_PERIOD, 10: cycles between subsequent auto-repeats; must be less than or equal to REPEAT_DELAY.
- GRAV_MAX, 3: saturation limit of the pending-gravity counter.

Ports:
- clk  input  1  system clock (hz100 domain)
- reset  input  1  asynchronous, active-high
- en_i  input  1  game active; low flushes all pending requests
- left_i  input  1  raw left button, asynchronous
- right_i  input  1  raw right button, asynchronous
- rot_r_i  input  1  raw rotate-right button, asynchronous
- rot_l_i  input  1  raw rotate-left button, asynchronous
- grav_tick_i  input  1  single-cycle gravity pulse, synchronous to clk
- cmd_ready_i  input  1  FSM accepts the command
- cmd_valid_o  output  1  command available
- cmd_o  output  3  command code: 0 DROP, 1 LEFT, 2 RIGHT, 3 ROT_R, 4 ROT_L
- grav_overflow_o  output  1  sticky flag: a gravity tick was lost at saturation

Behaviour:
- Reset values:
  - cmd_valid_o = 0, cmd_o = 0, grav_overflow_o = 0.
  - All sync flops, pending flags, repeat counters and the gravity counter = 0.
  - Round-robin pointer = ROT_L, so LEFT is searched first.
- Synchronisation and edge detection:
  - Each button passes through a 2-flop synchroniser, then a registered previous-value flop.
  - Rising edge = sync2 & ~prev.
  - A raw input rising before edge k sets its pending flag at edge k+2.
- Pending flags:
  - One bit per user source. Set on a rising edge or an auto-repeat event; cleared when that source's command is accepted.
  - A set event on an already-pending source is merged (no count).
  - A set and a clear in the same cycle leaves the flag set.
- Gravity counter:
  - Increments on grav_tick_i and decrements on DROP acceptance; both in the same cycle leaves it unchanged.
  - Saturates at GRAV_MAX. A tick arriving at saturation sets grav_overflow_o, which is cleared only by reset.
- State machine:
  - IDLE:
    - If en_i is high and any request is pending, register a grant at the next edge: cmd_valid_o = 1, cmd_o = winner, go to OFFER.
    - Winner: DROP if the gravity counter is nonzero; otherwise the first pending user source after the pointer, in the order LEFT, RIGHT, ROT_R, ROT_L, wrapping.
  - OFFER:
    - cmd_o is held stable while cmd_valid_o = 1 and cmd_ready_i = 0.
    - On cmd_valid_o & cmd_ready_i: clear the source (or decrement the counter), advance the pointer to the granted user source (the pointer is unchanged for DROP), and go to IDLE.
  - IDLE to OFFER takes one cycle, so back-to-back grants occur every 2 cycles.
  - Latency: raw press to cmd_valid_o = 3 edges when idle.
- en_i low:
  - All pending flags and the gravity counter clear.
  - cmd_valid_o drops at the next edge, even mid-OFFER; this is the only permitted abort.
  - Go to IDLE. The pointer and grav_overflow_o are retained.
  - Edges occurring while en_i is low are discarded.
- Reset mid-OFFER: everything returns immediately (asynchronously) to reset values.
- Simultaneous rising edges on several buttons: all set their pending flags; they are served in round-robin order.

Optional Feature:
- Macro: MOVE_AUTOREPEAT_EN.
- Defined:
  - LEFT and RIGHT each have a hold counter, cleared while the synchronised level is low and incremented while it is high.
  - When the counter reaches REPEAT_DELAY it sets pending and reloads to REPEAT_DELAY−REPEAT_PERIOD.
  - While en_i is low, the counters are held at 0.
- Undefined: no counters; only edges set pending.

Test Plan:
- Left press test:
  - Stimulus: left_i high from before edge 10, cmd_ready_i tied 1.
  - Required: cmd_valid_o high after edge 13 with cmd_o = 1; low after edge 14. Held button produces no second command (macro off).
- Gravity priority test:
  - Stimulus: grav_tick_i and a right press arrive so both are pending in the same cycle.
  - Required: DROP (0) is granted first, then RIGHT (2).
- Round-robin test:
  - Stimulus: all four buttons rise together, ready = 1.
  - Required: commands 1, 2, 3, 4 in order.
  - Follow-up: rot_l then left again gives 1 before 4.
- Backpressure test:
  - Stimulus: cmd_ready_i = 0 for 20 cycles while 5 grav ticks arrive.
  - Required: cmd_o stable at its first value; counter saturates at 3; grav_overflow_o = 1. After release, exactly 3 DROPs are issued.
- Abort and reset test:
  - Stimulus: en_i low during OFFER, then reset asserted mid-OFFER.
  - Required: en_i low drops cmd_valid_o next edge with no later commands; reset clears cmd_valid_o immediately without waiting for a clock.
- Auto-repeat test (MOVE_AUTOREPEAT_EN defined):
  - Stimulus: left held 60 cycles, ready = 1.
  - Required: LEFT at press, then at REPEAT_DELAY (30), 40, 50 cycles of sync-high hold; 4 commands total.
